// File: rtl/pe_tile_sequencer_pkg.sv
// Shared types for the PE tile sequencer: index widths, vector types, FSM states.
package pe_tile_sequencer_pkg;

    localparam int MAX_SEQ_LEN = 64;
    localparam int MAX_NUM_Q   = 64;
    localparam int KW          = $clog2(MAX_SEQ_LEN + 1);
    localparam int QW          = $clog2(MAX_NUM_Q + 1);

    // PE vector geometry: VEC_LEN elements of ELEM_W bits per Q/K/V row.
    localparam int ELEM_W      = 8;
    localparam int VEC_LEN     = 4;

    typedef logic [QW-1:0] Q_IDX_T;
    typedef logic [KW-1:0] KV_IDX_T;

    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] Q_VECTOR_T;
    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] K_VECTOR_T;
    typedef logic [VEC_LEN-1:0][ELEM_W-1:0] V_VECTOR_T;

    typedef struct packed {
        K_VECTOR_T k;
        V_VECTOR_T v;
    } KV_PAIR_T;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_Q,
        ST_WAIT_Q,
        ST_STREAM,
        ST_DRAIN,
        ST_FIN
    } PE_SEQ_STATE_T;

    // Out-of-range tile sizes saturate at the supported maximum.
    function automatic Q_IDX_T clamp_num_q(input Q_IDX_T v);
        return (v > Q_IDX_T'(MAX_NUM_Q)) ? Q_IDX_T'(MAX_NUM_Q) : v;
    endfunction

    function automatic KV_IDX_T clamp_num_kv(input KV_IDX_T v);
        return (v > KV_IDX_T'(MAX_SEQ_LEN)) ? KV_IDX_T'(MAX_SEQ_LEN) : v;
    endfunction

endpackage

// File: rtl/pe_tile_sequencer_kv_skid_fifo.sv
// Two-entry K/V skid FIFO: absorbs the one-cycle SRAM read latency while the PE stalls.
module kv_skid_fifo
    import pe_tile_sequencer_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  KV_PAIR_T push_data_i,
    input  logic     pop_i,
    output KV_PAIR_T head_o,
    output logic     full_o,
    output logic     empty_o
);

    KV_PAIR_T   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // Push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i));

endmodule

// File: rtl/pe_tile_sequencer.sv
// Walks one PE through an attention tile: Q row in, num_kv K/V beats, O row out, per query.
module pe_tile_sequencer
    import pe_tile_sequencer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  Q_IDX_T    cfg_num_q,
    input  KV_IDX_T   cfg_num_kv,
    output logic      busy,
    output logic      done,
    output logic      q_rd_en,
    output Q_IDX_T    q_rd_addr,
    input  Q_VECTOR_T q_rd_data,
    output logic      kv_rd_en,
    output KV_IDX_T   kv_rd_addr,
    input  K_VECTOR_T k_rd_data,
    input  V_VECTOR_T v_rd_data,
    output logic      pe_q_vld,
    input  logic      pe_q_rdy,
    output Q_VECTOR_T pe_q_vector,
    output logic      pe_kv_vld,
    input  logic      pe_k_rdy,
    input  logic      pe_v_rdy,
    output K_VECTOR_T pe_k_vector,
    output V_VECTOR_T pe_v_vector,
    output logic      pe_kv_last,
    input  logic      pe_o_vld,
    output logic      pe_o_rdy,
    input  logic      osram_rdy,
    output logic      o_wr_en,
    output Q_IDX_T    o_wr_addr
);

    PE_SEQ_STATE_T state_q;
    Q_IDX_T        num_q_q, q_idx_q, q_idx_d, start_nq;
    KV_IDX_T       num_kv_q, kv_issue_q, kv_issue_d, kv_sent_q, kv_sent_d, start_nkv;
    Q_VECTOR_T     q_vec_q;
    logic          pe_q_vld_q, done_q, inflight_q;
    KV_PAIR_T      fifo_head, fifo_in;
    logic          fifo_full, fifo_empty;
    logic [1:0]    fifo_cnt, occ;
    logic          beat, kv_rd, last_idx, o_wr;

    assign start_nq   = clamp_num_q(cfg_num_q);
    assign start_nkv  = clamp_num_kv(cfg_num_kv);
    assign q_idx_d    = q_idx_q + Q_IDX_T'(1);
    assign kv_issue_d = kv_issue_q + KV_IDX_T'(1);
    assign kv_sent_d  = kv_sent_q + KV_IDX_T'(1);

    // Occupancy counts the read in flight so the FIFO can never be oversubscribed.
    assign fifo_cnt  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occ       = fifo_cnt + {1'b0, inflight_q};
    assign pe_kv_vld = !fifo_empty;
    assign beat      = pe_kv_vld && pe_k_rdy && pe_v_rdy;
    assign last_idx  = (kv_sent_q == num_kv_q - KV_IDX_T'(1));
    assign kv_rd     = (state_q == ST_STREAM) && (kv_issue_q < num_kv_q) &&
                       ((occ - {1'b0, beat}) < 2'd2);
    assign o_wr      = pe_o_rdy && pe_o_vld;

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign q_rd_en     = (state_q == ST_LOAD_Q);
    assign q_rd_addr   = q_idx_q;
    assign kv_rd_en    = kv_rd;
    assign kv_rd_addr  = kv_issue_q;
    assign pe_q_vld    = pe_q_vld_q;
    assign pe_q_vector = q_vec_q;
    assign pe_k_vector = fifo_head.k;
    assign pe_v_vector = fifo_head.v;
    assign pe_kv_last  = pe_kv_vld && last_idx;
    assign pe_o_rdy    = (state_q == ST_DRAIN) && osram_rdy;
    assign o_wr_en     = o_wr;
    assign o_wr_addr   = q_idx_q;

    assign fifo_in.k = k_rd_data;
    assign fifo_in.v = v_rd_data;

    kv_skid_fifo u_kv_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_in),
        .pop_i       (beat),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Tile FSM with its counters, Q holding register and read-in-flight tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_q_q    <= '0;
            num_kv_q   <= '0;
            q_idx_q    <= '0;
            kv_issue_q <= '0;
            kv_sent_q  <= '0;
            q_vec_q    <= '0;
            pe_q_vld_q <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= kv_rd;
            if (kv_rd) kv_issue_q <= kv_issue_d;
            if (beat)  kv_sent_q  <= kv_sent_d;
            case (state_q)
                ST_IDLE: if (start) begin
                    num_q_q  <= start_nq;
                    num_kv_q <= start_nkv;
                    q_idx_q  <= '0;
                    state_q  <= (start_nq == '0 || start_nkv == '0) ? ST_FIN : ST_LOAD_Q;
                end
                ST_LOAD_Q: state_q <= ST_WAIT_Q;
                // First WAIT_Q cycle carries the SRAM data; afterwards hold until the PE takes it.
                ST_WAIT_Q: if (!pe_q_vld_q) begin
                    q_vec_q    <= q_rd_data;
                    pe_q_vld_q <= 1'b1;
                end else if (pe_q_rdy) begin
                    pe_q_vld_q <= 1'b0;
                    kv_issue_q <= '0;
                    kv_sent_q  <= '0;
                    state_q    <= ST_STREAM;
                end
                ST_STREAM: if (beat && last_idx) state_q <= ST_DRAIN;
                ST_DRAIN: if (o_wr) begin
                    if (q_idx_q == num_q_q - Q_IDX_T'(1)) begin
                        state_q <= ST_FIN;
                    end else begin
                        q_idx_q <= q_idx_d;
                        state_q <= ST_LOAD_Q;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Self-checking bench: SRAM/PE models, K/V/Q/O scoreboards, table of tiles plus corner sequences.
module tb_pe_tile_sequencer;
    import pe_tile_sequencer_pkg::*;

    logic clk = 1'b0, rst, start;
    Q_IDX_T cfg_num_q, q_rd_addr, o_wr_addr;
    KV_IDX_T cfg_num_kv, kv_rd_addr;
    logic busy, done, q_rd_en, kv_rd_en, pe_q_vld, pe_q_rdy, pe_kv_vld, pe_k_rdy, pe_v_rdy;
    logic pe_kv_last, pe_o_vld, pe_o_rdy, osram_rdy, o_wr_en;
    Q_VECTOR_T q_rd_data, pe_q_vector;
    K_VECTOR_T k_rd_data, pe_k_vector;
    V_VECTOR_T v_rd_data, pe_v_vector;

    pe_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_q(cfg_num_q), .cfg_num_kv(cfg_num_kv),
        .busy(busy), .done(done), .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .kv_rd_en(kv_rd_en), .kv_rd_addr(kv_rd_addr), .k_rd_data(k_rd_data), .v_rd_data(v_rd_data),
        .pe_q_vld(pe_q_vld), .pe_q_rdy(pe_q_rdy), .pe_q_vector(pe_q_vector),
        .pe_kv_vld(pe_kv_vld), .pe_k_rdy(pe_k_rdy), .pe_v_rdy(pe_v_rdy),
        .pe_k_vector(pe_k_vector), .pe_v_vector(pe_v_vector), .pe_kv_last(pe_kv_last),
        .pe_o_vld(pe_o_vld), .pe_o_rdy(pe_o_rdy), .osram_rdy(osram_rdy),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] qpat(input int a);
        return 32'h5100_0077 + 32'(a) * 32'h0101_0000;
    endfunction
    function automatic logic [31:0] kpat(input int a);
        return 32'h4B00_0000 + 32'(a) * 32'h0001_0203;
    endfunction
    function automatic logic [31:0] vpat(input int a);
        return 32'h5600_00FF ^ (32'(a) << 9);
    endfunction

    // SRAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= qpat(int'(q_rd_addr));
        if (kv_rd_en) begin
            k_rd_data <= kpat(int'(kv_rd_addr));
            v_rd_data <= vpat(int'(kv_rd_addr));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int q; int k; bit last; } kv_exp_t;
    kv_exp_t kvq[$];
    int qq[$], oq[$], rd_cyc[$], beat_cyc[$];

    // PE stimulus knobs.
    int k_pct = 100, v_pct = 100, q_pct = 100, o_pct = 100;
    bit stall = 0, o_hold = 0, o_pend = 0;

    initial begin
        pe_k_rdy = 0; pe_v_rdy = 0; pe_q_rdy = 0; osram_rdy = 0; pe_o_vld = 0;
        forever begin
            @(posedge clk); #1;
            pe_k_rdy  = !stall && (int'($urandom_range(99)) < k_pct);
            pe_v_rdy  = !stall && (int'($urandom_range(99)) < v_pct);
            pe_q_rdy  = int'($urandom_range(99)) < q_pct;
            osram_rdy = !o_hold && (int'($urandom_range(99)) < o_pct);
            pe_o_vld  = o_pend;
        end
    end

    // Monitor: scoreboards, read order, handshake stability, occupancy, strobe counters.
    int n_qrd = 0, n_kvrd = 0, n_qvld = 0, n_kvvld = 0, n_beat = 0, n_owr = 0, n_done = 0;
    int done_cyc = 0, exp_rd_addr = 0, reads_tot = 0, beats_tot = 0;
    bit kv_hold = 0, q_hold = 0;
    logic [31:0] prev_k, prev_v, prev_q;
    always @(negedge clk) begin
        if (rst) begin
            kv_hold = 0; q_hold = 0; reads_tot = 0; beats_tot = 0; exp_rd_addr = 0;
        end else begin
            automatic bit beat = pe_kv_vld && pe_k_rdy && pe_v_rdy;
            automatic bit qhs = pe_q_vld && pe_q_rdy;
            if (kv_hold) begin
                chk("kv_hold_vld", pe_kv_vld, 1);
                chk("kv_hold_k", pe_k_vector, prev_k);
                chk("kv_hold_v", pe_v_vector, prev_v);
            end
            if (q_hold) begin
                chk("q_hold_vld", pe_q_vld, 1);
                chk("q_hold_data", pe_q_vector, prev_q);
            end
            if (q_rd_en) n_qrd++;
            if (pe_q_vld) n_qvld++;
            if (pe_kv_vld) n_kvvld++;
            if (kv_rd_en) begin
                n_kvrd++; reads_tot++; rd_cyc.push_back(cyc);
                chk("kv_rd_addr", kv_rd_addr, exp_rd_addr);
                exp_rd_addr++;
            end
            if (beat) begin
                n_beat++; beats_tot++; beat_cyc.push_back(cyc);
                if (kvq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL kv_beat_unexpected: got beat k=%0h expected none", pe_k_vector);
                end else begin
                    automatic kv_exp_t e = kvq.pop_front();
                    chk("kv_k_data", pe_k_vector, kpat(e.k));
                    chk("kv_v_data", pe_v_vector, vpat(e.k));
                    chk("kv_last", pe_kv_last, e.last);
                    if (e.last) o_pend = 1;
                end
            end
            if (kv_rd_en || pe_kv_vld) chk("kv_occupancy_le2", (reads_tot - beats_tot) <= 2, 1);
            if (qhs) begin
                exp_rd_addr = 0;
                if (qq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL q_unexpected: got q=%0h expected none", pe_q_vector);
                end else chk("q_data", pe_q_vector, qpat(qq.pop_front()));
            end
            if (o_wr_en) begin
                n_owr++; o_pend = 0;
                chk("o_rdy_on_write", pe_o_rdy, 1);
                if (oq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL o_unexpected: got addr %0d expected none", o_wr_addr);
                end else chk("o_wr_addr", o_wr_addr, oq.pop_front());
            end
            if (done) begin n_done++; done_cyc = cyc; end
            kv_hold = pe_kv_vld && !beat; prev_k = pe_k_vector; prev_v = pe_v_vector;
            q_hold  = pe_q_vld && !qhs;   prev_q = pe_q_vector;
        end
    end

    task automatic start_tile(input int nq, input int nkv);
        automatic int cq = (nq > MAX_NUM_Q) ? MAX_NUM_Q : nq;
        automatic int ck = (nkv > MAX_SEQ_LEN) ? MAX_SEQ_LEN : nkv;
        if (ck > 0)
            for (int q = 0; q < cq; q++) begin
                qq.push_back(q);
                oq.push_back(q);
                for (int k = 0; k < ck; k++) kvq.push_back('{q, k, k == ck - 1});
            end
        @(posedge clk); #1;
        start = 1; cfg_num_q = Q_IDX_T'(nq); cfg_num_kv = KV_IDX_T'(nkv);
        @(posedge clk); #1;
        start = 0; cfg_num_q = Q_IDX_T'($urandom_range(127)); cfg_num_kv = KV_IDX_T'($urandom_range(127));
    endtask

    task automatic wait_done(input int d0, input string name);
        int t = 0;
        while (n_done == d0 && t < 5000) begin @(negedge clk); t++; end
        if (n_done == d0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, t);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic finish_tile(input int b0, input int w0, input int d0, input string name,
                               output int beats, output int writes, output int dones);
        wait_done(d0, name);
        beats = n_beat - b0; writes = n_owr - w0; dones = n_done - d0;
        chk("sb_kv_drained", kvq.size(), 0);
        chk("sb_q_drained", qq.size(), 0);
        chk("sb_o_drained", oq.size(), 0);
        chk("idle_after_tile", busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);            chk({tag, "_done"}, done, 0);
        chk({tag, "_q_rd_en"}, q_rd_en, 0);      chk({tag, "_kv_rd_en"}, kv_rd_en, 0);
        chk({tag, "_pe_q_vld"}, pe_q_vld, 0);    chk({tag, "_pe_kv_vld"}, pe_kv_vld, 0);
        chk({tag, "_pe_kv_last"}, pe_kv_last, 0); chk({tag, "_pe_o_rdy"}, pe_o_rdy, 0);
        chk({tag, "_o_wr_en"}, o_wr_en, 0);      chk({tag, "_kv_rd_addr"}, kv_rd_addr, 0);
        chk({tag, "_q_rd_addr"}, q_rd_addr, 0);  chk({tag, "_o_wr_addr"}, o_wr_addr, 0);
        chk({tag, "_pe_q_vector"}, pe_q_vector, 0);
        chk({tag, "_pe_k_vector"}, pe_k_vector, 0);
        chk({tag, "_pe_v_vector"}, pe_v_vector, 0);
    endtask

    typedef struct {
        int nq, nkv, kp, vp, op, qp;
        int exp_beats, exp_writes;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int b0, w0, d0, beats, writes, dones, t;
        int s0[5];
        tbl[0] = '{1, 4,   100, 100, 100, 100, 4,  1};
        tbl[1] = '{3, 5,   50,  50,  100, 100, 15, 3};
        tbl[2] = '{2, 3,   70,  40,  60,  50,  6,  2};
        tbl[3] = '{1, 100, 100, 100, 100, 100, 64, 1};
        tbl[4] = '{4, 1,   50,  50,  50,  100, 4,  4};

        rst = 1; start = 0; cfg_num_q = '0; cfg_num_kv = '0;
        repeat (3) @(posedge clk); #1;
        chk_zero("reset");
        rst = 0;

        // Table of whole tiles under varied PE/OSRAM readiness.
        for (int i = 0; i < 5; i++) begin
            k_pct = tbl[i].kp; v_pct = tbl[i].vp; o_pct = tbl[i].op; q_pct = tbl[i].qp;
            rd_cyc.delete(); beat_cyc.delete();
            b0 = n_beat; w0 = n_owr; d0 = n_done;
            start_tile(tbl[i].nq, tbl[i].nkv);
            finish_tile(b0, w0, d0, $sformatf("tbl%0d", i), beats, writes, dones);
            chk($sformatf("tbl%0d_beats", i), beats, tbl[i].exp_beats);
            chk($sformatf("tbl%0d_writes", i), writes, tbl[i].exp_writes);
            chk($sformatf("tbl%0d_done_once", i), dones, 1);
            if (i == 0) begin
                chk("t1_reads", rd_cyc.size(), 4);
                chk("t1_beat_count", beat_cyc.size(), 4);
                if (rd_cyc.size() == 4) chk("t1_reads_b2b", rd_cyc[3] - rd_cyc[0], 3);
                if (beat_cyc.size() == 4) chk("t1_beats_b2b", beat_cyc[3] - beat_cyc[0], 3);
            end
        end

        // PE stalls K and V for 10 cycles mid-stream; a stray start is ignored.
        k_pct = 100; v_pct = 100; o_pct = 100; q_pct = 100;
        b0 = n_beat; w0 = n_owr; d0 = n_done;
        start_tile(1, 8);
        t = 0;
        while (n_beat - b0 < 2 && t < 200) begin @(negedge clk); t++; end
        chk("stall_reached_stream", (n_beat - b0) >= 2, 1);
        @(posedge clk); #1;
        stall = 1; start = 1; cfg_num_q = 7'd5; cfg_num_kv = 7'd5;
        @(posedge clk); #1; start = 0;
        repeat (9) @(posedge clk);
        #1; stall = 0;
        finish_tile(b0, w0, d0, "stall", beats, writes, dones);
        chk("stall_beats", beats, 8);
        chk("stall_writes", writes, 1);
        chk("stall_done_once", dones, 1);

        // OSRAM not ready for 8 cycles while the PE holds its output.
        b0 = n_beat; w0 = n_owr; d0 = n_done;
        o_hold = 1;
        start_tile(1, 2);
        t = 0;
        while (!pe_o_vld && t < 200) begin @(negedge clk); t++; end
        for (int i = 0; i < 8; i++) begin
            chk("oblk_pe_o_rdy", pe_o_rdy, 0);
            chk("oblk_no_write", o_wr_en, 0);
            @(negedge clk);
        end
        o_hold = 0;
        @(negedge clk);
        chk("oblk_write_on_rise", o_wr_en, 1);
        finish_tile(b0, w0, d0, "oblk", beats, writes, dones);
        chk("oblk_writes", writes, 1);

        // Empty tiles: done two cycles after start, no SRAM or PE activity.
        for (int i = 0; i < 2; i++) begin
            automatic int st;
            s0 = '{n_qrd, n_kvrd, n_qvld, n_kvvld, n_owr};
            d0 = n_done;
            @(posedge clk); #1;
            start = 1; cfg_num_q = (i == 0) ? 7'd3 : 7'd0; cfg_num_kv = (i == 0) ? 7'd0 : 7'd4;
            st = cyc;
            @(posedge clk); #1; start = 0;
            wait_done(d0, "empty");
            chk("empty_done_latency", done_cyc - st, 2);
            chk("empty_done_once", n_done - d0, 1);
            chk("empty_no_q_rd", n_qrd - s0[0], 0);
            chk("empty_no_kv_rd", n_kvrd - s0[1], 0);
            chk("empty_no_pe_q", n_qvld - s0[2], 0);
            chk("empty_no_pe_kv", n_kvvld - s0[3], 0);
            chk("empty_no_o_wr", n_owr - s0[4], 0);
        end

        // Reset during STREAM aborts at once; a fresh tile then completes.
        start_tile(2, 6);
        t = 0;
        while (!pe_kv_vld && t < 200) begin @(negedge clk); t++; end
        @(posedge clk); #3;
        rst = 1; #1;
        chk_zero("abort");
        kvq.delete(); qq.delete(); oq.delete(); o_pend = 0;
        d0 = n_done;
        repeat (2) @(posedge clk); #1; rst = 0;
        repeat (6) @(posedge clk); #1;
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_idle", busy, 0);
        b0 = n_beat; w0 = n_owr; d0 = n_done;
        start_tile(1, 2);
        finish_tile(b0, w0, d0, "post_rst", beats, writes, dones);
        chk("post_rst_beats", beats, 2);
        chk("post_rst_writes", writes, 1);
        chk("post_rst_done_once", dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $fatal(1);
    end

endmodule
